frame_buffer_writer: RTL and testbench

//   Write side of the 2:2:2 RGB frame buffer that the display pixel loader reads.
//   - Accepts a valid/ready pixel stream. A start-of-frame flag marks each frame's first pixel.
//   - Produces linear write-port transactions (address, R, G, B) into the frame-buffer RAM.
//   - Covers H_ACTIVE x V_ACTIVE pixels in raster order; address = y*H_ACTIVE + x.
//   - Sits between the pixel source (e.g. the UART/byte unpacker) and the RAM write port.

---
 rtl/frame_buffer_writer.sv | 127 ++++++++++++
 tb/tb_frame_buffer_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - write side of the 2:2:2 RGB frame buffer
// Turns a valid/ready pixel stream with start-of-frame flag into linear RAM writes.
module frame_buffer_writer #(
   parameter int H_ACTIVE = 400,
   parameter int V_ACTIVE = 300,
   parameter int PIX_W    = 2,
   parameter int ADDR_W   = 17
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_sof,
   input  logic [3*PIX_W-1:0]   s_data,
   input  logic                 hold,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [PIX_W-1:0]     wr_r,
   output logic [PIX_W-1:0]     wr_g,
   output logic [PIX_W-1:0]     wr_b,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 sof_err
);

   localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIX - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   pcnt;
   logic [ADDR_W-1:0]   pcnt_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic                wr_en_nxt;
   logic                done_nxt;
   logic                err_nxt;
   logic                accept;
   logic                at_last;

   // Ready depends only on hold so a stall never drops an offered beat.
   assign s_ready = rst_n & ~hold;
   assign accept  = s_valid & s_ready;
   assign at_last = (pcnt == LAST_PIX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && s_sof) begin
               state_nxt = FILL;
            end
         end
         FILL: begin
            if (accept && !s_sof && at_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An SOF always restarts at address 0, whether idle or mid-frame.
   always_comb begin
      wr_en_nxt = 1'b0;
      addr_nxt  = pcnt;
      pcnt_nxt  = pcnt;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (accept) begin
         if (s_sof) begin
            wr_en_nxt = 1'b1;
            addr_nxt  = '0;
            pcnt_nxt  = ADDR_W'(1);
            err_nxt   = (state == FILL);
         end else if (state == FILL) begin
            wr_en_nxt = 1'b1;
            addr_nxt  = pcnt;
            if (at_last) begin
               done_nxt = 1'b1;
               pcnt_nxt = '0;
            end else begin
               pcnt_nxt = pcnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt       <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_r       <= '0;
         wr_g       <= '0;
         wr_b       <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
      end else begin
         pcnt       <= pcnt_nxt;
         wr_en      <= wr_en_nxt;
         frame_done <= done_nxt;
         sof_err    <= err_nxt;
         busy       <= (state_nxt == FILL);
         if (wr_en_nxt) begin
            wr_addr <= addr_nxt;
            wr_r    <= s_data[3*PIX_W-1:2*PIX_W];
            wr_g    <= s_data[2*PIX_W-1:PIX_W];
            wr_b    <= s_data[PIX_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb/tb_frame_buffer_writer.sv - randomized self-checking bench for frame_buffer_writer
// Reduced 8x5 frame keeps full-frame, resync and reset scenarios short.
module tb_frame_buffer_writer;

   localparam int H  = 8;
   localparam int V  = 5;
   localparam int P  = 2;
   localparam int AW = 6;
   localparam int FP = H * V;

   logic          clk;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic          s_sof;
   logic [3*P-1:0] s_data;
   logic          hold;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [P-1:0]  wr_r;
   logic [P-1:0]  wr_g;
   logic [P-1:0]  wr_b;
   logic          busy;
   logic          frame_done;
   logic          sof_err;

   frame_buffer_writer #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .PIX_W    (P),
      .ADDR_W   (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_sof      (s_sof),
      .s_data     (s_data),
      .hold       (hold),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_r       (wr_r),
      .wr_g       (wr_g),
      .wr_b       (wr_b),
      .busy       (busy),
      .frame_done (frame_done),
      .sof_err    (sof_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: frame progress tracked as "inside a frame" plus next pixel index.
   bit         in_frame;
   int         nxt_pix;
   bit         e_wr;
   int         e_addr;
   logic [5:0] e_data;
   bit         e_done;
   bit         e_err;
   int         done_exp;
   int         done_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      in_frame = 1'b0;
      nxt_pix  = 0;
      e_wr     = 1'b0;
      e_addr   = 0;
      e_data   = '0;
      e_done   = 1'b0;
      e_err    = 1'b0;
   endtask

   task automatic model_beat(input bit sof, input logic [5:0] d);
      if (sof) begin
         e_wr     = 1'b1;
         e_addr   = 0;
         e_data   = d;
         e_err    = in_frame;
         in_frame = 1'b1;
         nxt_pix  = 1;
      end else if (in_frame) begin
         e_wr    = 1'b1;
         e_addr  = nxt_pix;
         e_data  = d;
         e_done  = (nxt_pix == FP - 1);
         nxt_pix = nxt_pix + 1;
         if (nxt_pix == FP) begin
            in_frame = 1'b0;
            nxt_pix  = 0;
         end
      end
      if (e_done) done_exp++;
   endtask

   task automatic compare_outputs();
      check("wr_en", wr_en, e_wr);
      check("wr_addr", wr_addr, e_addr);
      check("wr_r", wr_r, e_data[5:4]);
      check("wr_g", wr_g, e_data[3:2]);
      check("wr_b", wr_b, e_data[1:0]);
      check("frame_done", frame_done, e_done);
      check("sof_err", sof_err, e_err);
      check("busy", busy, in_frame);
      if (frame_done === 1'b1) done_seen++;
   endtask

   // One clock: drive at the falling edge, predict, compare at the next falling edge.
   task automatic tick(input bit v, input bit sof, input logic [5:0] d, input bit h);
      s_valid = v;
      s_sof   = sof;
      s_data  = d;
      hold    = h;
      #1;
      check("s_ready", s_ready, rst_n & ~h);
      e_wr   = 1'b0;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (v && rst_n && !h) model_beat(sof, d);
      @(posedge clk);
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      for (int i = 0; i < cycles; i++) begin
         tick(1'b1, 1'($urandom_range(1)), 6'($urandom), 1'b0);
      end
      rst_n = 1'b1;
   endtask

   // mode 0: continuous, data = index (SOF carries 6'h3F); 1: hold toggles every 3 cycles; 2: random
   task automatic send_frame(input int mode, input int len);
      int         sent;
      int         k;
      bit         v;
      bit         h;
      logic [5:0] d;
      sent = 0;
      k    = 0;
      while (sent < len && k < 20 * len + 100) begin
         case (mode)
            0: begin
               v = 1'b1;
               h = 1'b0;
               d = (sent == 0) ? 6'h3F : 6'(sent % 64);
            end
            1: begin
               v = 1'b1;
               h = ((k / 3) % 2) == 1;
               d = 6'($urandom);
            end
            default: begin
               v = ($urandom_range(3) != 0);
               h = ($urandom_range(4) == 0);
               d = 6'($urandom);
            end
         endcase
         tick(v, sent == 0, d, h);
         if (v && !h) sent++;
         k++;
      end
      check("beats_sent", sent, len);
   endtask

   initial begin
      rst_n     = 1'b0;
      s_valid   = 1'b0;
      s_sof     = 1'b0;
      s_data    = '0;
      hold      = 1'b0;
      done_exp  = 0;
      done_seen = 0;
      model_reset();
      @(negedge clk);

      do_reset(4);

      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 6'($urandom), 1'b0);
      send_frame(0, FP);
      tick(1'b0, 1'b0, 6'h00, 1'b0);
      tick(1'b0, 1'b0, 6'h00, 1'b0);
      check("done_after_full", done_seen, done_exp);

      send_frame(2, 20);
      send_frame(2, FP);
      check("done_after_resync", done_seen, done_exp);

      send_frame(0, FP);
      send_frame(2, FP);
      send_frame(0, FP - 1);
      send_frame(0, FP);
      check("done_back_to_back", done_seen, done_exp);

      send_frame(1, FP);
      send_frame(1, FP);
      check("done_after_hold", done_seen, done_exp);

      send_frame(2, 25);
      do_reset(3);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 6'($urandom), 1'b0);
      send_frame(0, FP);
      check("done_after_reset", done_seen, done_exp);

      for (int i = 0; i < 400; i++) begin
         tick($urandom_range(3) != 0, $urandom_range(40) == 0, 6'($urandom), $urandom_range(5) == 0);
      end
      check("done_random", done_seen, done_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
